// File: rtl/prog_dump_tx_if.sv
// rtl/prog_dump_tx_if.sv - program memory read port between the dump transmitter and program RAM
interface prog_dump_tx_if;
    logic [15:0] prog_add;
    logic        prog_re;
    logic [15:0] prog_data;

    modport master (
        output prog_add,
        output prog_re,
        input  prog_data
    );

    modport slave (
        input  prog_add,
        input  prog_re,
        output prog_data
    );
endinterface

// File: rtl/prog_dump_tx.sv
// rtl/prog_dump_tx.sv - reads program memory word by word and sends it as 8N1 UART bytes (PROG_DUMP_CSUM_EN appends a checksum byte)
module prog_dump_tx #(
    parameter int BAUD_DIV = 217,
    parameter int WORDS    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    prog_dump_tx_if.master        mem,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND_LO,
        S_SEND_HI,
        S_FIN
`ifdef PROG_DUMP_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [16:0] LAST_ADDR   = 17'(WORDS - 1);

    state_t      state_q, state_d;
    logic [16:0] addr_q, addr_d;
    logic [15:0] word_q, word_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
`ifdef PROG_DUMP_CSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        sending;
    logic        frame_end;
    logic        load;
    logic [7:0]  load_byte;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef PROG_DUMP_CSUM_EN
        sum_d     = sum_q;
`endif
        load      = 1'b0;
        load_byte = 8'h00;

        sending = (state_q == S_SEND_LO) || (state_q == S_SEND_HI)
`ifdef PROG_DUMP_CSUM_EN
                  || (state_q == S_CSUM)
`endif
                  ;
        frame_end = sending && (baud_q == 16'd0) && (bit_q == 4'd9);

        // Bit serialiser: each bit holds for BAUD_DIV clocks, the stop bit ends the frame.
        if (sending) begin
            if (baud_q != 16'd0) begin
                baud_d = baud_q - 16'd1;
            end else if (bit_q != 4'd9) begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
                baud_d  = BAUD_RELOAD;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = 17'd0;
                    busy_d  = 1'b1;
`ifdef PROG_DUMP_CSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                word_d    = mem.prog_data;
                load      = 1'b1;
                load_byte = mem.prog_data[7:0];
                state_d   = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (frame_end) begin
                    load      = 1'b1;
                    load_byte = word_q[15:8];
                    state_d   = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (frame_end) begin
                    if (addr_q == LAST_ADDR) begin
`ifdef PROG_DUMP_CSUM_EN
                        load      = 1'b1;
                        load_byte = ~sum_q + 8'd1;
                        state_d   = S_CSUM;
`else
                        state_d   = S_FIN;
`endif
                    end else begin
                        addr_d  = addr_q + 17'd1;
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef PROG_DUMP_CSUM_EN
            S_CSUM: begin
                if (frame_end) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new frame starts with its start bit on the very next clock, so frames abut.
        if (load) begin
            shift_d = {1'b1, load_byte};
            tx_d    = 1'b0;
            baud_d  = BAUD_RELOAD;
            bit_d   = 4'd0;
`ifdef PROG_DUMP_CSUM_EN
            sum_d   = sum_q + load_byte;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= 17'd0;
            word_q  <= 16'd0;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shift_q <= 9'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PROG_DUMP_CSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef PROG_DUMP_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign mem.prog_add = addr_q[15:0];
    assign mem.prog_re  = (state_q == S_FETCH);
    assign uart_tx      = tx_q;
    assign busy         = busy_q;
    assign done         = (state_q == S_FIN);

endmodule
